// File: rtl/ffm_arbiter_if.sv
// Requester and multiplier bundle around the ffm arbiter.
// master: the arbiter; slave: requesters plus the ffm.
interface ffm_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 255
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      res;
  logic              busy;
  logic              err;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [W-1:0]      mul_res;
  logic              mul_valid;

  modport master (
    input  req,
    input  a_in,
    input  b_in,
    output gnt,
    output done,
    output res,
    output busy,
    output err,
    output mul_start,
    output mul_a,
    output mul_b,
    input  mul_res,
    input  mul_valid
  );

  modport slave (
    output req,
    output a_in,
    output b_in,
    input  gnt,
    input  done,
    input  res,
    input  busy,
    input  err,
    input  mul_start,
    input  mul_a,
    input  mul_b,
    output mul_res,
    output mul_valid
  );
endinterface

// File: rtl/ffm_arbiter.sv
// Round-robin share of one ffm multiplier among NREQ sequencers.
// Define FFM_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module ffm_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 255,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  ffm_arbiter_if.master bus
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LIM = (TIMEOUT > MIN_LAT)
                     ? TIMEOUT : MIN_LAT;
  localparam int CW  = $clog2(LIM + 2);
  localparam logic [CW-1:0] ACC_AT =
    CW'((MIN_LAT > 0) ? MIN_LAT - 1 : 0);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

`ifdef FFM_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_AT = CW'(TIMEOUT);
  logic            err_q, err_d;
`endif

  logic [W-1:0]    a_slc [NREQ];
  logic [W-1:0]    b_slc [NREQ];
  logic            pick_ok;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;
  int              scan_sum;

  for (genvar j = 0; j < NREQ; j++) begin : g_slc
    assign a_slc[j] = bus.a_in[j*W +: W];
    assign b_slc[j] = bus.b_in[j*W +: W];
  end

  // scan starts one past the last winner, so it
  // has the lowest priority next time round
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = ptr_q;
    scan_sum = 0;
    scan_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_sum = int'(ptr_q) + i;
      if (scan_sum >= NREQ)
        scan_sum = scan_sum - NREQ;
      scan_idx = PW'(scan_sum);
      if (!pick_ok && bus.req[scan_idx]) begin
        pick_ok  = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef FFM_ARB_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          ptr_d           = pick_idx;
          a_d             = a_slc[pick_idx];
          b_d             = b_slc[pick_idx];
          start_d         = 1'b1;
          busy_d          = 1'b1;
          cnt_d           = '0;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
        // a valid level left over from a previous
        // op is masked until MIN_LAT has elapsed
        if (bus.mul_valid && cnt_q >= ACC_AT) begin
          res_d   = bus.mul_res;
          done_d  = gnt_q;
          state_d = RELEASE;
        end
`ifdef FFM_ARB_TIMEOUT_EN
        else if (cnt_q >= TO_AT) begin
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = RELEASE;
        end
`endif
      end
      RELEASE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
`ifdef FFM_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef FFM_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.res       = res_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;

`ifdef FFM_ARB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ffm_arbiter.sv
// Bench for ffm_arbiter: ffm model mod 2^255-19,
// round-robin reference, randomized operations.
module tb_ffm_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 255;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 8;
  localparam logic [W-1:0] P = {W{1'b1}} - W'(18);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ffm_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  ffm_arbiter #(
    .NREQ   (NREQ),
    .W      (W),
    .MIN_LAT(MIN_LAT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] opa [NREQ];
  logic [W-1:0] opb [NREQ];
  int           mptr;

  function automatic logic [W-1:0] modmul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    logic [2*W-1:0] xx, yy, pp;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    pp = (xx * yy) % {{W{1'b0}}, P};
    return pp[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[W-33:0], 32'($urandom)};
    v[W-1] = 1'b0;
    return v;
  endfunction

  function automatic int rr_pick(
    input logic [NREQ-1:0] r,
    input int p
  );
    for (int i = 1; i <= NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // ffm model: result lat cycles after start
  int           ffm_lat   = 4;
  bit           ffm_on    = 1'b1;
  bit           ffm_stale = 1'b0;
  bit           ffm_kick  = 1'b0;
  int           cd        = 0;
  logic [W-1:0] fa = '0;
  logic [W-1:0] fb = '0;

  always @(negedge clk) begin
    bus.mul_valid = 1'b0;
    if (!rst) begin
      cd          = 0;
      bus.mul_res = '0;
    end else if (bus.mul_start === 1'b1) begin
      fa = bus.mul_a;
      fb = bus.mul_b;
      cd = ffm_lat;
      if (ffm_stale) begin
        bus.mul_valid = 1'b1;
        bus.mul_res   = ~modmul(fa, fb);
      end
    end else if (ffm_kick) begin
      ffm_kick      = 1'b0;
      bus.mul_valid = 1'b1;
      bus.mul_res   = modmul(fa, fb);
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0 && ffm_on) begin
        bus.mul_valid = 1'b1;
        bus.mul_res   = modmul(fa, fb);
      end
    end
  end

  task automatic drive_ops();
    for (int j = 0; j < NREQ; j++) begin
      bus.a_in[j*W +: W] = opa[j];
      bus.b_in[j*W +: W] = opb[j];
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 50);
    if (bus.gnt == '0) n = -1;
  endtask

  task automatic wait_done(output int n, output int b1h);
    n   = 0;
    b1h = 0;
    do begin
      @(negedge clk);
      n++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.done))
        b1h++;
    end while (bus.done == '0 && n < 80);
    if (bus.done == '0) n = -1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.gnt, bus.done, bus.busy, bus.err,
         bus.mul_start} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b req=0",
               {bus.gnt, bus.done, bus.busy,
                bus.err, bus.mul_start});
    end
    total++;
    if ({bus.res, bus.mul_a, bus.mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_data res=%h a=%h b=%h req=0",
               bus.res, bus.mul_a, bus.mul_b);
    end
    rst  = 1'b1;
    mptr = NREQ - 1;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.busy} !== '0) begin
      bad++;
      $display("FAIL idle_hold gnt=%b busy=%b req=0",
               bus.gnt, bus.busy);
    end
  endtask

  task automatic test_single();
    int n, b1h;
    opa[1]  = W'(3);
    opb[1]  = W'(5);
    drive_ops();
    ffm_lat = 4;
    bus.req = 4'b0010;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    total++;
    if (n !== 1 || bus.gnt !== 4'b0010
        || bus.mul_start !== 1'b1) begin
      bad++;
      $display("FAIL single_gnt n=%0d gnt=%b st=%b req 1 0010 1",
               n, bus.gnt, bus.mul_start);
    end
    total++;
    if (bus.mul_a !== W'(3) || bus.mul_b !== W'(5)) begin
      bad++;
      $display("FAIL single_ops a=%0d b=%0d req 3 5",
               bus.mul_a, bus.mul_b);
    end
    wait_done(n, b1h);
    total++;
    if (n !== 5 || bus.done !== 4'b0010) begin
      bad++;
      $display("FAIL single_done n=%0d done=%b req 5 0010",
               n, bus.done);
    end
    total++;
    if (bus.res !== W'(15) || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_res res=%0d busy=%b req 15 1",
               bus.res, bus.busy);
    end
    bus.req = '0;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.busy, bus.done} !== '0) begin
      bad++;
      $display("FAIL single_release got=%b req=0",
               {bus.gnt, bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, b1h;
    ffm_on  = 1'b0;
    bus.req = 4'b0100;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    total++;
    if (bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_gnt gnt=%b req 0100", bus.gnt);
    end
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    bus.req = '0;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.busy, bus.mul_start} !== '0) begin
      bad++;
      $display("FAIL midrst_clear got=%b req=0",
               {bus.gnt, bus.busy, bus.mul_start});
    end
    rst    = 1'b1;
    ffm_on = 1'b1;
    mptr   = NREQ - 1;
    opa[0] = rnd_fe();
    opb[0] = rnd_fe();
    drive_ops();
    bus.req = 4'b1001;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_ptr gnt=%b req 0001", bus.gnt);
    end
    wait_done(n, b1h);
    total++;
    if (bus.done !== 4'b0001
        || bus.res !== modmul(opa[0], opb[0])) begin
      bad++;
      $display("FAIL midrst_res done=%b res=%h req 0001 %h",
               bus.done, bus.res, modmul(opa[0], opb[0]));
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n, b1h, e;
    rst = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    mptr = NREQ - 1;
    for (int j = 0; j < NREQ; j++) begin
      opa[j] = rnd_fe();
      opb[j] = rnd_fe();
    end
    drive_ops();
    ffm_lat = 3;
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      e    = rr_pick(bus.req, mptr);
      mptr = e;
      wait_gnt(n);
      total++;
      if (bus.gnt !== (NREQ'(1) << e)
          || (k > 0 && n !== 2)) begin
        bad++;
        $display("FAIL rr_gnt k=%0d gnt=%b n=%0d req %b 2",
                 k, bus.gnt, n, NREQ'(1) << e);
      end
      wait_done(n, b1h);
      total++;
      if (bus.done !== (NREQ'(1) << e) || b1h !== 0) begin
        bad++;
        $display("FAIL rr_done k=%0d done=%b b1h=%0d req %b 0",
                 k, bus.done, b1h, NREQ'(1) << e);
      end
      total++;
      if (bus.res !== modmul(opa[e], opb[e])) begin
        bad++;
        $display("FAIL rr_res k=%0d res=%h req %h",
                 k, bus.res, modmul(opa[e], opb[e]));
      end
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_stale_valid();
    int n, b1h;
    opa[3]    = rnd_fe();
    opb[3]    = rnd_fe();
    drive_ops();
    ffm_lat   = 3;
    ffm_stale = 1'b1;
    bus.req   = 4'b1000;
    mptr      = rr_pick(bus.req, mptr);
    wait_gnt(n);
    wait_done(n, b1h);
    total++;
    if (n !== 4 || bus.done !== 4'b1000) begin
      bad++;
      $display("FAIL stale_lat n=%0d done=%b req 4 1000",
               n, bus.done);
    end
    total++;
    if (bus.res !== modmul(opa[3], opb[3])) begin
      bad++;
      $display("FAIL stale_res res=%h req %h",
               bus.res, modmul(opa[3], opb[3]));
    end
    ffm_stale = 1'b0;
    bus.req   = '0;
    @(negedge clk);
  endtask

  task automatic test_operand_capture();
    int n, b1h, extra;
    logic [W-1:0] xa, xb;
    xa      = rnd_fe();
    xb      = rnd_fe();
    opa[0]  = xa;
    opb[0]  = xb;
    drive_ops();
    ffm_lat = 4;
    bus.req = 4'b0001;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    opa[0]  = ~xa;
    opb[0]  = ~xb;
    drive_ops();
    bus.req = '0;
    @(negedge clk);
    total++;
    if (bus.mul_start !== 1'b0) begin
      bad++;
      $display("FAIL cap_start st=%b req 0", bus.mul_start);
    end
    @(negedge clk);
    total++;
    if (bus.mul_a !== xa || bus.mul_b !== xb) begin
      bad++;
      $display("FAIL cap_ops a=%h b=%h req %h %h",
               bus.mul_a, bus.mul_b, xa, xb);
    end
    wait_done(n, b1h);
    total++;
    if (bus.done !== 4'b0001
        || bus.res !== modmul(xa, xb)) begin
      bad++;
      $display("FAIL cap_done done=%b res=%h req 0001 %h",
               bus.done, bus.res, modmul(xa, xb));
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done != '0 || bus.gnt != '0) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL cap_once extra=%0d req 0", extra);
    end
  endtask

`ifdef FFM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, b1h, extra;
    ffm_on  = 1'b0;
    bus.req = 4'b0100;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    wait_done(n, b1h);
    total++;
    if (n !== TIMEOUT + 1 || bus.done !== 4'b0100
        || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL to_pulse n=%0d done=%b err=%b req %0d 0100 1",
               n, bus.done, bus.err, TIMEOUT + 1);
    end
    bus.req = '0;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.busy, bus.err, bus.done} !== '0) begin
      bad++;
      $display("FAIL to_idle got=%b req=0",
               {bus.gnt, bus.busy, bus.err, bus.done});
    end
    ffm_on   = 1'b1;
    ffm_kick = 1'b1;
    extra    = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done != '0 || bus.busy != 1'b0) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL to_stray extra=%0d req 0", extra);
    end
  endtask
`else
  task automatic test_no_watchdog();
    int n, b1h, seen;
    ffm_on  = 1'b0;
    opa[2]  = rnd_fe();
    opb[2]  = rnd_fe();
    drive_ops();
    bus.req = 4'b0100;
    mptr    = rr_pick(bus.req, mptr);
    wait_gnt(n);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done != '0 || bus.err != 1'b0) seen++;
    end
    total++;
    if (seen !== 0 || bus.busy !== 1'b1
        || bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL nowd_hold seen=%0d busy=%b gnt=%b req 0 1 0100",
               seen, bus.busy, bus.gnt);
    end
    ffm_on   = 1'b1;
    ffm_kick = 1'b1;
    wait_done(n, b1h);
    total++;
    if (bus.done !== 4'b0100 || bus.err !== 1'b0
        || bus.res !== modmul(opa[2], opb[2])) begin
      bad++;
      $display("FAIL nowd_done done=%b err=%b res=%h req 0100 0 %h",
               bus.done, bus.err, bus.res,
               modmul(opa[2], opb[2]));
    end
    bus.req = '0;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int n, b1h, e;
    logic [NREQ-1:0] m;
    for (int k = 0; k < 12; k++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int j = 0; j < NREQ; j++)
        if (m[j] && !bus.req[j]) begin
          opa[j] = rnd_fe();
          opb[j] = rnd_fe();
        end
      drive_ops();
      bus.req   = bus.req | m;
      ffm_lat   = $urandom_range(2, 6);
      ffm_stale = 1'($urandom_range(0, 1));
      e         = rr_pick(bus.req, mptr);
      mptr      = e;
      wait_gnt(n);
      total++;
      if (bus.gnt !== (NREQ'(1) << e)) begin
        bad++;
        $display("FAIL rnd_gnt k=%0d gnt=%b req %b",
                 k, bus.gnt, NREQ'(1) << e);
      end
      wait_done(n, b1h);
      total++;
      if (n !== ffm_lat + 1 || b1h !== 0
          || bus.done !== (NREQ'(1) << e)) begin
        bad++;
        $display("FAIL rnd_done k=%0d n=%0d done=%b req %0d %b",
                 k, n, bus.done, ffm_lat + 1, NREQ'(1) << e);
      end
      total++;
      if (bus.res !== modmul(opa[e], opb[e])) begin
        bad++;
        $display("FAIL rnd_res k=%0d res=%h req %h",
                 k, bus.res, modmul(opa[e], opb[e]));
      end
      bus.req[e] = 1'b0;
    end
    ffm_stale = 1'b0;
    bus.req   = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < NREQ; j++) begin
      opa[j] = '0;
      opb[j] = '0;
    end
    test_reset();
    test_single();
    test_reset_mid_wait();
    test_round_robin();
    test_stale_valid();
    test_operand_capture();
`ifdef FFM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_watchdog();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim did not finish total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end
endmodule
